// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared defaults and config type for the multi-channel clock divider
package clock_div_pkg;
  localparam int DEFAULT_DIV_W = 26;
  localparam int unsigned DEFAULT_RESET_PERIOD = 49_999_999;
  localparam int unsigned DEFAULT_RESET_HIGH = 25_000_000;
  typedef struct packed {
    logic [DEFAULT_DIV_W-1:0] period;
    logic [DEFAULT_DIV_W-1:0] high;
  } div_cfg_t;
endpackage

// File: rtl/clock_div_chan.sv
// clock_div_chan: one divider channel with shadowed period/high config applied at period boundaries
module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W,
  parameter int unsigned RESET_PERIOD = DEFAULT_RESET_PERIOD,
  parameter int unsigned RESET_HIGH = DEFAULT_RESET_HIGH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic             sync_in,
  input  logic [DIV_W-1:0] cfg_period_in,
  input  logic [DIV_W-1:0] cfg_high_in,
  input  logic             cfg_load_in,
  output logic             clk_out,
  output logic             tick_out,
  output logic             pending_out
);
  typedef struct packed {
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] high;
  } cfg_t;
  localparam cfg_t RESET_CFG = '{period: DIV_W'(RESET_PERIOD), high: DIV_W'(RESET_HIGH)};
  cfg_t act, shadow, cfg, act_next;
  logic [DIV_W-1:0] count, count_inc;
  logic idle, restart;
  always_comb begin
    cfg = '{period: cfg_period_in, high: cfg_high_in};
    restart = en_in & (idle | sync_in | (count == act.period));
    // a load coinciding with a boundary bypasses the shadow entirely
    act_next = cfg_load_in ? cfg : pending_out ? shadow : act;
    count_inc = count + DIV_W'(1);
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count <= '0;
      idle <= 1'b1;
      pending_out <= 1'b0;
      act <= RESET_CFG;
      shadow <= RESET_CFG;
      clk_out <= 1'b0;
      tick_out <= 1'b0;
    end else if (!en_in) begin
      count <= '0;
      idle <= 1'b1;
      clk_out <= 1'b0;
      tick_out <= 1'b0;
      if (pending_out) act <= shadow;
      if (cfg_load_in) shadow <= cfg;
      pending_out <= cfg_load_in;
    end else if (restart) begin
      act <= act_next;
      shadow <= act_next;
      pending_out <= 1'b0;
      count <= '0;
      idle <= 1'b0;
      tick_out <= 1'b1;
      clk_out <= act_next.high != '0;
    end else begin
      count <= count_inc;
      tick_out <= 1'b0;
      clk_out <= count_inc < act.high;
      if (cfg_load_in) begin
        shadow <= cfg;
        pending_out <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/clock_div_multi.sv
// clock_div_multi: multi-channel runtime-programmable clock/strobe divider
// with glitch-free shadowed reconfiguration and a global re-phase sync.
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DIV_W = DEFAULT_DIV_W,
  parameter int unsigned RESET_PERIOD = DEFAULT_RESET_PERIOD,
  parameter int unsigned RESET_HIGH = DEFAULT_RESET_HIGH
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [CHANNELS-1:0] en_in,
  input  logic                sync_in,
  input  logic [DIV_W-1:0]    cfg_period_in,
  input  logic [DIV_W-1:0]    cfg_high_in,
  input  logic [CHANNELS-1:0] cfg_load_in,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick_out,
  output logic [CHANNELS-1:0] pending_out
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clock_div_chan #(
      .DIV_W(DIV_W),
      .RESET_PERIOD(RESET_PERIOD),
      .RESET_HIGH(RESET_HIGH)
    ) u_chan (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .en_in(en_in[i]),
      .sync_in(sync_in),
      .cfg_period_in(cfg_period_in),
      .cfg_high_in(cfg_high_in),
      .cfg_load_in(cfg_load_in[i]),
      .clk_out(clk_out[i]),
      .tick_out(tick_out[i]),
      .pending_out(pending_out[i])
    );
  end
endmodule

// File: tb/tb_clock_div_multi.sv
// tb_clock_div_multi: directed pattern checks plus randomized run against a period/phase reference model
module tb_clock_div_multi;
  localparam int CH = 4;
  localparam int W = 26;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic [CH-1:0] en_in = '0;
  logic sync_in = 1'b0;
  logic [W-1:0] cfg_period_in = '0;
  logic [W-1:0] cfg_high_in = '0;
  logic [CH-1:0] cfg_load_in = '0;
  logic [CH-1:0] clk_out, tick_out, pending_out;
  int n_cmp = 0;
  int n_bad = 0;
  int m_p[CH], m_h[CH], s_p[CH], s_h[CH], m_pos[CH];
  logic [CH-1:0] m_clk, m_tick, m_pend;

  clock_div_multi #(.CHANNELS(CH), .DIV_W(W), .RESET_PERIOD(7), .RESET_HIGH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .sync_in(sync_in),
    .cfg_period_in(cfg_period_in), .cfg_high_in(cfg_high_in), .cfg_load_in(cfg_load_in),
    .clk_out(clk_out), .tick_out(tick_out), .pending_out(pending_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_p[c] = 7; m_h[c] = 4; s_p[c] = 7; s_h[c] = 4; m_pos[c] = -1;
    end
    m_clk = '0; m_tick = '0; m_pend = '0;
  endtask

  // Each channel sits at a phase within its period (-1 when idle); a new period begins at phase 0.
  task automatic model_edge();
    bit start;
    if (rst_in) begin model_reset(); return; end
    for (int c = 0; c < CH; c++) begin
      if (!en_in[c]) begin
        if (m_pend[c]) begin m_p[c] = s_p[c]; m_h[c] = s_h[c]; end
        m_pend[c] = cfg_load_in[c];
        if (cfg_load_in[c]) begin s_p[c] = int'(cfg_period_in); s_h[c] = int'(cfg_high_in); end
        m_pos[c] = -1; m_clk[c] = 0; m_tick[c] = 0;
      end else begin
        start = (m_pos[c] < 0) || sync_in || (m_pos[c] == m_p[c]);
        if (start) begin
          if (cfg_load_in[c]) begin
            m_p[c] = int'(cfg_period_in); m_h[c] = int'(cfg_high_in); s_p[c] = m_p[c]; s_h[c] = m_h[c];
          end else if (m_pend[c]) begin
            m_p[c] = s_p[c]; m_h[c] = s_h[c];
          end
          m_pend[c] = 0; m_pos[c] = 0;
        end else begin
          m_pos[c] = m_pos[c] + 1;
          if (cfg_load_in[c]) begin s_p[c] = int'(cfg_period_in); s_h[c] = int'(cfg_high_in); m_pend[c] = 1; end
        end
        m_tick[c] = start;
        m_clk[c] = m_pos[c] < m_h[c];
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    sync_in = 1'b0;
    cfg_load_in = '0;
  endtask

  task automatic program_chan(int c, int p, int h);
    en_in[c] = 1'b0;
    cfg_period_in = W'(p);
    cfg_high_in = W'(h);
    cfg_load_in = '0;
    cfg_load_in[c] = 1'b1;
    step();
    step();
    en_in[c] = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    n_cmp++;
    if ({clk_out, tick_out, pending_out} !== '0) begin
      n_bad++; $display("FAIL reset outputs got %b want 0", {clk_out, tick_out, pending_out});
    end
    rst_in = 1'b0;
  endtask

  task automatic test_basic();
    logic [2:0] got, exp;
    cfg_period_in = W'(3); cfg_high_in = W'(2); cfg_load_in = 4'b0001;
    step();
    n_cmp++;
    if (pending_out[0] !== 1'b1) begin n_bad++; $display("FAIL basic pending got %b want 1", pending_out[0]); end
    en_in[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      got = {clk_out[0], tick_out[0], pending_out[0]};
      exp = {k % 4 < 2, k % 4 == 0, 1'b0};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL basic k=%0d clk/tick/pend got %b want %b", k, got, exp); end
    end
  endtask

  task automatic test_reload();
    logic [2:0] got, exp;
    step();
    step();
    cfg_period_in = W'(5); cfg_high_in = W'(1); cfg_load_in = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      step();
      got = {clk_out[0], tick_out[0], pending_out[0]};
      n_cmp++;
      if (got !== 3'b001) begin n_bad++; $display("FAIL reload tail k=%0d got %b want 001", k, got); end
    end
    for (int k = 0; k < 12; k++) begin
      step();
      got = {clk_out[0], tick_out[0], pending_out[0]};
      exp = {k % 6 == 0, k % 6 == 0, 1'b0};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL reload k=%0d got %b want %b", k, got, exp); end
    end
  endtask

  task automatic test_bounds();
    logic [1:0] got, exp;
    program_chan(0, 3, 0);
    for (int k = 0; k < 8; k++) begin
      step(); got = {clk_out[0], tick_out[0]}; exp = {1'b0, k % 4 == 0}; n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL bound_h0 k=%0d got %b want %b", k, got, exp); end
    end
    program_chan(0, 3, 9);
    for (int k = 0; k < 8; k++) begin
      step(); got = {clk_out[0], tick_out[0]}; exp = {1'b1, k % 4 == 0}; n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL bound_hgtp k=%0d got %b want %b", k, got, exp); end
    end
    program_chan(0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      step(); got = {clk_out[0], tick_out[0]}; n_cmp++;
      if (got !== 2'b11) begin n_bad++; $display("FAIL bound_p0 k=%0d got %b want 11", k, got); end
    end
  endtask

  task automatic test_sync();
    logic [2:0] got_c, got_t, exp_c, exp_t;
    program_chan(0, 3, 2);
    step();
    program_chan(1, 2, 1);
    step();
    step();
    for (int k = 0; k < 9; k++) begin
      if (k == 0) sync_in = 1'b1;
      step();
      got_c = clk_out[2:0]; got_t = tick_out[2:0];
      exp_c = {1'b0, k % 3 < 1, k % 4 < 2};
      exp_t = {1'b0, k % 3 == 0, k % 4 == 0};
      n_cmp++;
      if ({got_c, got_t} !== {exp_c, exp_t})
        begin n_bad++; $display("FAIL sync k=%0d clk/tick got %b/%b want %b/%b", k, got_c, got_t, exp_c, exp_t); end
    end
  endtask

  task automatic test_disable();
    logic [1:0] got, exp;
    step();
    en_in[0] = 1'b0;
    for (int d = 0; d < 3; d++) begin
      if (d == 1) begin cfg_period_in = W'(5); cfg_high_in = W'(1); cfg_load_in = 4'b0001; end
      step();
      got = {clk_out[0], tick_out[0]}; n_cmp++;
      if (got !== 2'b00) begin n_bad++; $display("FAIL disable d=%0d clk/tick got %b want 00", d, got); end
      if (d > 0) begin
        n_cmp++;
        if (pending_out[0] !== (d == 1))
          begin n_bad++; $display("FAIL disable_pend d=%0d got %b want %b", d, pending_out[0], d == 1); end
      end
    end
    en_in[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(); got = {clk_out[0], tick_out[0]}; exp = {k % 6 == 0, k % 6 == 0}; n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL reenable k=%0d got %b want %b", k, got, exp); end
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] got, exp;
    cfg_period_in = W'(2); cfg_high_in = W'(1); cfg_load_in = 4'b1000;
    step();
    n_cmp++;
    if (pending_out[3] !== 1'b1) begin n_bad++; $display("FAIL areset_pre pending3 got %b want 1", pending_out[3]); end
    @(negedge clk_in);
    rst_in = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({clk_out, tick_out, pending_out} !== '0)
      begin n_bad++; $display("FAIL areset outputs got %b want 0", {clk_out, tick_out, pending_out}); end
    en_in = 4'b0001;
    step();
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step(); got = {clk_out[0], tick_out[0]}; exp = {k % 8 < 4, k % 8 == 0}; n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL areset_period k=%0d got %b want %b", k, got, exp); end
    end
  endtask

  task automatic test_random();
    en_in = 4'b1111;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 15) == 0) en_in[c] = ~en_in[c];
        cfg_load_in[c] = ($urandom_range(0, 5) == 0);
      end
      sync_in = ($urandom_range(0, 19) == 0);
      cfg_period_in = W'($urandom_range(0, 7));
      cfg_high_in = W'($urandom_range(0, 9));
      step();
      n_cmp++;
      if ({clk_out, tick_out, pending_out} !== {m_clk, m_tick, m_pend})
        begin n_bad++; $display("FAIL random n=%0d clk/tick/pend got %b/%b/%b want %b/%b/%b",
                                n, clk_out, tick_out, pending_out, m_clk, m_tick, m_pend); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_bounds();
    test_sync();
    test_disable();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clock_div_multi.md
Name: clock_div_multi

Overview:
Multi-channel, runtime-programmable clock/strobe divider. It is the successor to the fixed-count 50%-duty divider.
- Each channel has its own period and high-time (duty), an enable, and a one-cycle tick at period start.
- Configuration changes are shadowed and take effect only at a period boundary, so outputs are glitch-free.
- A global sync re-phases all channels.
- Sits in the clock_in domain and feeds LED blinkers, sample strobes and slow peripheral enables.

Parameters:
- CHANNELS, 4, number of independent divider channels (≥1).
- DIV_W, 26, width of the period/high counters.
- RESET_PERIOD, 49_999_999, active period value after reset (period = value+1 cycles; 1 Hz at 50 MHz).
- RESET_HIGH, 25_000_000, active high-time value after reset (50% duty for RESET_PERIOD).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- en_in  input  CHANNELS  per-channel enable, level.
- sync_in  input  1  one-cycle pulse; restarts every enabled channel at count 0.
- cfg_period_in  input  DIV_W  new period value P (period = P+1 cycles).
- cfg_high_in  input  DIV_W  new high-time H (clk_out high for H cycles of each period).
- cfg_load_in  input  CHANNELS  one-hot/multi-hot strobe; captures cfg_* into the shadow of each selected channel.
- clk_out  output  CHANNELS  registered divided clock per channel.
- tick_out  output  CHANNELS  registered one-cycle pulse on the first cycle of each period.
- pending_out  output  CHANNELS  shadow holds values not yet applied.

Behaviour:
- Per-channel state: count[DIV_W], active P/H, shadow P/H, pending, idle.
- Reset (async) values:
  - count=0, idle=1, pending=0, active and shadow = RESET_PERIOD/RESET_HIGH.
  - clk_out=0, tick_out=0, pending_out=0.
- Restart condition, evaluated at each posedge: R = en & (idle | sync_in | count==active P).
- Enabled edge with R:
  - If pending, apply the shadow to active first.
  - count←0, tick_out←1, idle←0.
- Enabled edge without R: count←count+1, tick_out←0.
- clk_out is registered from the new count: clk_out←(count_next < H_eff), where H_eff is the active H after any apply on that edge.
- Duty boundaries:
  - H=0 → clk_out constantly 0.
  - H>P → constantly 1.
  - P=0 → tick every cycle; clk_out=(H≠0).
- Disabled edge (en=0):
  - count←0, idle←1, clk_out←0, tick_out←0.
  - If pending, apply the shadow immediately and clear pending.
- Re-enable: on the first enabled edge, idle forces R, so a full period starts with a tick. Latency from en high to first tick is 1 edge.
- Load: cfg_load_in[i] writes shadow[i] and sets pending.
- Load on the same edge as R: the incoming cfg values go directly to active and pending stays 0.
- Repeated loads before a boundary: last write wins.
- sync_in:
  - Acts as R for all enabled channels, regardless of count.
  - Disabled channels ignore it.
  - Pending shadows apply on sync.
- Counter arithmetic is unsigned DIV_W. count never exceeds active P, and active P only changes at R, so no wrap beyond P.
- pending_out = pending (registered).
- Reset asserted mid-period returns every channel to reset values immediately. On release, each enabled channel ticks on its first edge.

Decomposition:
- Package clock_div_pkg holds:
  - DIV_W default, and the reset-default constants RESET_PERIOD and RESET_HIGH.
  - Typedef div_cfg_t {period, high}.
- One sub-module, clock_div_chan: a single channel with its count, shadow, apply and output logic.
- The top generates CHANNELS instances sharing sync_in and the cfg_* buses.

Test Plan:
- Reset, load ch0 P=3 H=2, en0=1 → tick0 on the first edge then every 4 cycles; clk_out0 pattern 1,1,0,0 repeating; pending_out0 1 only until the first tick.
- Load P=5 H=1 while at count=1 of a P=3 period → old 1100 period completes; pending_out=1 until the boundary; then 100000 repeating with tick on its first cycle.
- Boundaries:
  - H=0 → clk_out stays 0, ticks continue.
  - H=9, P=3 → clk_out stays 1.
  - P=0 H=1 → tick and clk_out high every cycle.
- Two channels (P=3, P=2) running out of phase, sync_in pulse → both tick on the next edge and count from 0 together; a disabled channel stays at 0.
- en toggled low for 3 cycles mid-period → clk_out/tick 0 while low; first edge after re-enable produces a tick; a load during disable applies immediately (pending_out falls next edge).
- rst_in asserted asynchronously between edges mid-period → clk_out, tick_out, pending_out drop to 0 without a clock; after release the period is RESET values (check with small override RESET_PERIOD=7 RESET_HIGH=4 → 11110000).
